// File: rtl/qreg_shift.sv
// Q (multiplier) register for the shift-add multiplier: parallel load, right shift
// with serial-in, iteration counter and busy/done handshake. Optional macro: QREG_BOOTH_EN.
module qreg_shift #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             shift_en,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  output logic             q_lsb,
  output logic [CW-1:0]    count,
  output logic             busy,
  output logic             done
`ifdef QREG_BOOTH_EN
  , output logic [1:0]     booth_op
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_data;
  logic [CW-1:0]    r_count;
  logic             r_busy;
  logic             r_done;
  logic             w_last;

  assign w_last = (r_count == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (load) begin
      r_state <= SHIFT;
      r_data  <= data_in;
      r_count <= '0;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
    end else if (r_state == SHIFT && shift_en) begin
      r_data  <= {serial_in, r_data[WIDTH-1:1]};
      r_count <= r_count + CW'(1);
      if (w_last) begin
        r_state <= DONE;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
      end
    end
  end

`ifdef QREG_BOOTH_EN
  logic r_q_m1;

  // Q-1 captures the bit shifted out, only on shifts the main register accepts
  always_ff @(posedge clk) begin
    if (reset || load) begin
      r_q_m1 <= 1'b0;
    end else if (r_state == SHIFT && shift_en) begin
      r_q_m1 <= r_data[0];
    end
  end

  assign booth_op = {r_data[0], r_q_m1};
`endif

  assign data_out = r_data;
  assign q_lsb    = r_data[0];
  assign count    = r_count;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_qreg_shift.sv
// Directed self-checking bench for qreg_shift at WIDTH=8; define QREG_BOOTH_EN to
// also exercise the Booth Q-1 outputs.
module tb_qreg_shift;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH + 1);

  logic             clk;
  logic             reset;
  logic             load;
  logic [WIDTH-1:0] data_in;
  logic             shift_en;
  logic             serial_in;
  logic [WIDTH-1:0] data_out;
  logic             q_lsb;
  logic [CW-1:0]    count;
  logic             busy;
  logic             done;
`ifdef QREG_BOOTH_EN
  logic [1:0]       booth_op;
`endif

  int unsigned n_checks;
  int unsigned n_fail;

  qreg_shift #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .data_in   (data_in),
    .shift_en  (shift_en),
    .serial_in (serial_in),
    .data_out  (data_out),
    .q_lsb     (q_lsb),
    .count     (count),
    .busy      (busy),
    .done      (done)
`ifdef QREG_BOOTH_EN
    , .booth_op(booth_op)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] d, input int c,
                         input logic b, input logic dn);
    chk({tag, ".data"},  32'(data_out), 32'(d));
    chk({tag, ".count"}, 32'(count),    32'(c));
    chk({tag, ".busy"},  32'(busy),     32'(b));
    chk({tag, ".done"},  32'(done),     32'(dn));
    chk({tag, ".qlsb"},  32'(q_lsb),    32'(d[0]));
  endtask

  logic [7:0] exp55 [8];
  logic [7:0] expAA [7];

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    exp55     = '{8'h2A, 8'h15, 8'h0A, 8'h05, 8'h02, 8'h01, 8'h00, 8'h00};
    expAA     = '{8'hEA, 8'hF5, 8'hFA, 8'hFD, 8'hFE, 8'hFF, 8'hFF};
    reset     = 1'b1;
    load      = 1'b0;
    data_in   = '0;
    shift_en  = 1'b0;
    serial_in = 1'b0;
    #1;
    step();
    step();
    chk_all("reset", 8'h00, 0, 1'b0, 1'b0);

    reset    = 1'b0;
    shift_en = 1'b1;
    step();
    step();
    chk_all("idle_shift", 8'h00, 0, 1'b0, 1'b0);

    // 0x55 with serial_in=0
    shift_en = 1'b0;
    load     = 1'b1;
    data_in  = 8'h55;
    step();
    load = 1'b0;
    chk_all("load55", 8'h55, 0, 1'b1, 1'b0);
    shift_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk_all($sformatf("s55_%0d", i + 1), exp55[i], i + 1, (i == 7) ? 1'b0 : 1'b1,
              (i == 7) ? 1'b1 : 1'b0);
    end
    step();
    step();
    chk_all("s55_extra", 8'h00, 8, 1'b0, 1'b1);

    // 0xAA with serial_in=1 and a 3-cycle gap
    shift_en  = 1'b0;
    serial_in = 1'b1;
    load      = 1'b1;
    data_in   = 8'hAA;
    step();
    load     = 1'b0;
    shift_en = 1'b1;
    step();
    chk_all("sAA_1", 8'hD5, 1, 1'b1, 1'b0);
    shift_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all($sformatf("gap_%0d", i), 8'hD5, 1, 1'b1, 1'b0);
    end
    shift_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      chk_all($sformatf("sAA_%0d", i + 2), expAA[i], i + 2, (i == 6) ? 1'b0 : 1'b1,
              (i == 6) ? 1'b1 : 1'b0);
    end

    // Abort mid-sequence with a reload; same-cycle shift_en ignored
    shift_en  = 1'b0;
    serial_in = 1'b0;
    load      = 1'b1;
    data_in   = 8'hFF;
    step();
    load     = 1'b0;
    shift_en = 1'b1;
    step();
    step();
    step();
    chk_all("sFF_3", 8'h1F, 3, 1'b1, 1'b0);
    load    = 1'b1;
    data_in = 8'h0F;
    step();
    load = 1'b0;
    chk_all("reload", 8'h0F, 0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step();
    chk_all("s0F_5", 8'h00, 5, 1'b1, 1'b0);

    // Reset beats load and shift_en
    reset   = 1'b1;
    load    = 1'b1;
    data_in = 8'hC3;
    step();
    chk_all("reset_prio", 8'h00, 0, 1'b0, 1'b0);
    reset = 1'b0;
    load  = 1'b0;
    step();
    chk_all("post_reset_idle", 8'h00, 0, 1'b0, 1'b0);

`ifdef QREG_BOOTH_EN
    shift_en  = 1'b0;
    serial_in = 1'b0;
    load      = 1'b1;
    data_in   = 8'h06;
    step();
    load = 1'b0;
    chk("booth_load", 32'(booth_op), 32'h0);
    shift_en = 1'b1;
    step();
    chk("booth_d1", 32'(data_out), 32'h03);
    chk("booth_1",  32'(booth_op), 32'h2);
    step();
    chk("booth_d2", 32'(data_out), 32'h01);
    chk("booth_2",  32'(booth_op), 32'h3);
    step();
    chk("booth_d3", 32'(data_out), 32'h00);
    chk("booth_3",  32'(booth_op), 32'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/qreg_shift.md
Name: qreg_shift

Overview:
- Parametrised Q (multiplier) register for the sequential shift-add multiplier datapath. Next generation of the fixed 8-bit Q register.
- Adds a parallel load, right-shift with serial-in from the A register LSB, a built-in iteration counter and a busy/done handshake to the controller.
- Sits between the multiplier controller FSM and the A/Q shift pair. The controller issues load once, then shift_en per iteration, and waits for done.

Parameters:
- WIDTH, 8, operand/register width in bits (>=2)
- CW, $clog2(WIDTH+1), iteration counter width (derived, not overridden)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- load  input  1  load data_in and start a new multiply sequence
- data_in  input  WIDTH  multiplier operand
- shift_en  input  1  perform one right-shift iteration
- serial_in  input  1  bit shifted into MSB (A register LSB)
- data_out  output  WIDTH  current Q register contents
- q_lsb  output  1  data_out[0], drives the controller's add decision
- count  output  CW  shifts completed since last load
- busy  output  1  sequence in progress
- done  output  1  WIDTH shifts completed; held until next load or reset

Behaviour:
- Reset is synchronous and active-high on one clock (clk). When reset=1 at a rising edge: data_out=0, count=0, busy=0, done=0, state=IDLE. reset overrides load and shift_en.
- States: IDLE, SHIFT, DONE.
- Priority at each edge is reset > load > shift_en.
- load=1 in any state: data_out<=data_in, count<=0, busy<=1, done<=0, next state SHIFT.
  - load while busy aborts the current sequence and restarts. No error is flagged.
  - A shift_en in the same cycle as load is ignored.
- SHIFT with shift_en=1: data_out<={serial_in, data_out[WIDTH-1:1]}, count<=count+1.
  - If count==WIDTH-1 before the edge: count becomes WIDTH, busy<=0, done<=1, next state DONE. done is visible the cycle after the final shift.
- SHIFT with shift_en=0: all state holds. Gaps between shifts are legal.
- IDLE/DONE with shift_en=1: ignored. data_out, count and done hold. No wrap past WIDTH.
- DONE holds data_out and count=WIDTH until load or reset.
- Latency: load to first shift-capable cycle is 1 clock. A full sequence is 1 + WIDTH clocks with shift_en held high.
- q_lsb is purely combinational from data_out[0].
- busy and done are registered and never both 1.

Optional Feature:
- Macro: QREG_BOOTH_EN
- Defined:
  - Adds a q_m1 flop (the Booth Q-1 bit), cleared by reset and load.
  - On each accepted shift, q_m1<=data_out[0].
  - Adds output port booth_op [1:0] = {data_out[0], q_m1}, combinational.
  - All other behaviour is unchanged.
- Undefined: no q_m1 flop and no booth_op port. The block is plain shift-add.

Test Plan (WIDTH=8):
- reset=1 for 2 clocks, then release -> data_out=0x00, count=0, busy=0, done=0. shift_en pulses in IDLE -> no change.
- load data_in=0x55, serial_in=0, shift_en=1 for 8 clocks:
  - data_out sequence 0x2A, 0x15, 0x0A, 0x05, 0x02, 0x01, 0x00, 0x00.
  - done=1 and count=8 the cycle after the 8th shift. Extra shifts leave count=8.
- load 0xAA, serial_in=1:
  - After 1 shift data_out=0xD5.
  - After 8 shifts data_out=0xFF and done=1.
  - shift_en deasserted for 3 clocks mid-sequence -> data_out and count frozen.
- load 0xFF, 3 shifts with serial_in=0 (data_out=0x1F, count=3), then load 0x0F -> data_out=0x0F, count=0, busy=1, done=0. Same-cycle shift_en is ignored.
- reset asserted with load and shift_en high at count=5 -> all outputs 0, state IDLE next cycle.
- QREG_BOOTH_EN defined: load 0x06, serial_in=0:
  - booth_op=00 after load.
  - After shift 1: data_out=0x03, booth_op=10.
  - After shift 2: data_out=0x01, booth_op=11.
  - After shift 3: data_out=0x00, booth_op=01.
